// File: rtl/collatz_sweep_ctrl.sv
// Sweeps N over [n_first, n_last], launches the Collatz core per value and keeps the N with the largest count.
// Optional running total of sampled counts on sum_count when COLLATZ_SWEEP_SUM_EN is defined.
module collatz_sweep_ctrl #(
  parameter int N_W     = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [N_W-1:0]   n_first,
  input  logic [N_W-1:0]   n_last,
  output logic [N_W-1:0]   core_n,
  output logic             core_start,
  input  logic             core_busy,
  input  logic [CNT_W-1:0] core_count,
  output logic             active,
  output logic             done,
  output logic             err,
  output logic [N_W-1:0]   best_n,
`ifdef COLLATZ_SWEEP_SUM_EN
  output logic [CNT_W-1:0] best_count,
  output logic [15:0]      sum_count
`else
  output logic [CNT_W-1:0] best_count
`endif
);

  // state | meaning: IDLE reset/idle, WAIT_IDLE core not yet free, LAUNCH start pulse,
  // WAIT_BUSY expect busy ack, RUN core iterating, NEXT compare/advance, DONE sweep finished
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_IDLE = 3'd1;
  localparam logic [2:0] S_LAUNCH    = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [N_W-1:0]   cur_q, cur_d;
  logic [N_W-1:0]   last_q, last_d;
  logic [N_W-1:0]   core_n_q, core_n_d;
  logic [N_W-1:0]   best_n_q, best_n_d;
  logic [CNT_W-1:0] best_count_q, best_count_d;
  logic [CNT_W-1:0] cur_count_q, cur_count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic             core_start_q, active_q, done_q;
`ifdef COLLATZ_SWEEP_SUM_EN
  logic [15:0]      sum_q, sum_d;
  logic [16:0]      sum_add;
  assign sum_add   = {1'b0, sum_q} + 17'(cur_count_q);
  assign sum_count = sum_q;
`endif

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    core_n_d     = core_n_q;
    best_n_d     = best_n_q;
    best_count_d = best_count_q;
    cur_count_d  = cur_count_q;
    timer_d      = timer_q;
    err_d        = err_q;
`ifdef COLLATZ_SWEEP_SUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          cur_d        = n_first;
          last_d       = n_last;
          best_n_d     = '0;
          best_count_d = '0;
          err_d        = 1'b0;
`ifdef COLLATZ_SWEEP_SUM_EN
          sum_d        = '0;
`endif
          if (n_first > n_last) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (!core_busy) begin
          // N=0 has no Collatz trajectory; the core is never asked about it
          if (cur_q == '0) begin
            cur_count_d = '0;
            state_d     = S_NEXT;
          end else begin
            core_n_d = cur_q;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (core_busy) begin
          timer_d = TMR_LOAD;
          state_d = S_RUN;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        // count is valid only on the first idle cycle, so sampling wins over the timeout
        if (!core_busy) begin
          cur_count_d = core_count;
          state_d     = S_NEXT;
        end else if (timer_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_NEXT: begin
        if (cur_count_q > best_count_q) begin
          best_n_d     = cur_q;
          best_count_d = cur_count_q;
        end
`ifdef COLLATZ_SWEEP_SUM_EN
        sum_d = sum_add[16] ? 16'hFFFF : sum_add[15:0];
`endif
        if (cur_q == last_q) begin
          state_d = S_DONE;
        end else begin
          cur_d   = cur_q + N_W'(1);
          state_d = S_WAIT_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      core_n_q     <= '0;
      best_n_q     <= '0;
      best_count_q <= '0;
      cur_count_q  <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
`ifdef COLLATZ_SWEEP_SUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      core_n_q     <= core_n_d;
      best_n_q     <= best_n_d;
      best_count_q <= best_count_d;
      cur_count_q  <= cur_count_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      core_start_q <= (state_d == S_LAUNCH);
      active_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
`ifdef COLLATZ_SWEEP_SUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign core_n     = core_n_q;
  assign core_start = core_start_q;
  assign active     = active_q;
  assign done       = done_q;
  assign err        = err_q;
  assign best_n     = best_n_q;
  assign best_count = best_count_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Directed bench for collatz_sweep_ctrl with a table-driven core model (busy k cycles, count valid one cycle).
module tb_collatz_sweep_ctrl;
  localparam int N_W = 8;
  localparam int CNT_W = 8;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic [N_W-1:0] n_first = '0;
  logic [N_W-1:0] n_last = '0;
  logic [N_W-1:0] core_n;
  logic core_start;
  logic core_busy = 1'b0;
  logic [CNT_W-1:0] core_count = '0;
  logic active, done, err;
  logic [N_W-1:0] best_n;
  logic [CNT_W-1:0] best_count;
`ifdef COLLATZ_SWEEP_SUM_EN
  logic [15:0] sum_count;
`endif

  int checks = 0;
  int errors = 0;
  int tbl[256];
  int hang_n = 85;
  logic core_recover = 1'b0;
  int starts = 0;
  int rem = 0;
  logic hung = 1'b0;
  logic [CNT_W-1:0] result = '0;

  collatz_sweep_ctrl #(.N_W(N_W), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .n_first(n_first), .n_last(n_last),
    .core_n(core_n), .core_start(core_start), .core_busy(core_busy), .core_count(core_count),
    .active(active), .done(done), .err(err), .best_n(best_n),
`ifdef COLLATZ_SWEEP_SUM_EN
    .best_count(best_count), .sum_count(sum_count)
`else
    .best_count(best_count)
`endif
  );

  always #5 clk = ~clk;

  // core model: busy for tbl[N] cycles after seeing start, count valid one cycle after busy drops
  always @(posedge clk) begin
    if (core_start) starts <= starts + 1;
    if (core_recover) begin
      core_busy  <= 1'b0;
      core_count <= '0;
      hung       <= 1'b0;
    end else if (core_busy) begin
      if (!hung) begin
        if (rem <= 1) begin
          core_busy  <= 1'b0;
          core_count <= result;
        end else begin
          rem <= rem - 1;
        end
      end
    end else begin
      core_count <= '0;
      if (core_start) begin
        core_busy <= 1'b1;
        rem       <= tbl[core_n];
        result    <= CNT_W'(tbl[core_n]);
        hung      <= (int'(core_n) == hang_n);
      end
    end
  end

  task automatic go_sweep(input logic [N_W-1:0] f, input logic [N_W-1:0] l);
    @(negedge clk);
    n_first = f;
    n_last  = l;
    go      = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({core_n, core_start, active, done, err, best_n, best_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: n=%0d st=%0b act=%0b done=%0b err=%0b bn=%0d bc=%0d, required all 0",
               core_n, core_start, active, done, err, best_n, best_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep_basic();
    int s0, cyc;
    tbl[1] = 3; tbl[2] = 1; tbl[3] = 7; tbl[4] = 2;
    s0 = starts;
    go_sweep(8'd1, 8'd4);
    checks++;
    if (active !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_active: active=%0b done=%0b, required 1/0", active, done);
    end
    repeat (6) @(negedge clk);
    n_first = 8'd9; n_last = 8'd9; go = 1'b1;
    @(negedge clk);
    go = 1'b0; n_first = 8'd1; n_last = 8'd4;
    wait_done(200, cyc);
    cyc = cyc + 7;
    checks++;
    if (cyc != 29) begin errors++; $display("FAIL basic_latency: %0d cycles, required 29", cyc); end
    checks++;
    if (best_n !== 8'd3 || best_count !== 8'd7) begin
      errors++;
      $display("FAIL basic_best: best_n=%0d best_count=%0d, required 3/7", best_n, best_count);
    end
    checks++;
    if (err !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: err=%0b active=%0b, required 0/0", err, active);
    end
    checks++;
    if (starts - s0 != 4) begin errors++; $display("FAIL basic_starts: %0d, required 4", starts - s0); end
`ifdef COLLATZ_SWEEP_SUM_EN
    checks++;
    if (sum_count !== 16'd13) begin errors++; $display("FAIL basic_sum: %0d, required 13", sum_count); end
`endif
  endtask

  task automatic test_single();
    int s0, cyc;
    tbl[2] = 1;
    s0 = starts;
    go_sweep(8'd2, 8'd2);
    wait_done(50, cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL single_latency: done after %0d cycles, required 5", cyc); end
    checks++;
    if (starts - s0 != 1 || core_n !== 8'd2) begin
      errors++;
      $display("FAIL single_launch: starts=%0d core_n=%0d, required 1/2", starts - s0, core_n);
    end
    checks++;
    if (best_n !== 8'd2 || best_count !== 8'd1) begin
      errors++;
      $display("FAIL single_best: best_n=%0d best_count=%0d, required 2/1", best_n, best_count);
    end
  endtask

  task automatic test_zero_first();
    int s0, cyc;
    tbl[1] = 3;
    s0 = starts;
    go_sweep(8'd0, 8'd1);
    wait_done(50, cyc);
    checks++;
    if (cyc != 9) begin errors++; $display("FAIL zero_latency: %0d cycles, required 9", cyc); end
    checks++;
    if (starts - s0 != 1) begin errors++; $display("FAIL zero_starts: %0d, required 1", starts - s0); end
    checks++;
    if (best_n !== 8'd1 || best_count !== 8'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_best: best_n=%0d best_count=%0d err=%0b, required 1/3/0", best_n, best_count, err);
    end
`ifdef COLLATZ_SWEEP_SUM_EN
    checks++;
    if (sum_count !== 16'd3) begin errors++; $display("FAIL zero_sum: %0d, required 3", sum_count); end
`endif
  endtask

  task automatic test_top_tie();
    int s0, cyc;
    tbl[254] = 4; tbl[255] = 4;
    s0 = starts;
    go_sweep(8'd254, 8'd255);
    wait_done(60, cyc);
    checks++;
    if (cyc != 16 || starts - s0 != 2) begin
      errors++;
      $display("FAIL top_nowrap: cycles=%0d starts=%0d, required 16/2", cyc, starts - s0);
    end
    checks++;
    if (best_n !== 8'd254 || best_count !== 8'd4) begin
      errors++;
      $display("FAIL top_tie: best_n=%0d best_count=%0d, required 254/4", best_n, best_count);
    end
  endtask

  task automatic test_bad_range();
    int s0;
    s0 = starts;
    go_sweep(8'd5, 8'd3);
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("FAIL bad_range_flags: err=%0b done=%0b active=%0b, required 1/1/0", err, done, active);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (starts - s0 != 0 || best_count !== 8'd0) begin
      errors++;
      $display("FAIL bad_range_nolaunch: starts=%0d best_count=%0d, required 0/0", starts - s0, best_count);
    end
  endtask

  task automatic test_timeout();
    int s0, cyc;
    s0 = starts;
    go_sweep(8'd85, 8'd85);
    wait_done(TO + 50, cyc);
    checks++;
    if (cyc != TO + 3) begin errors++; $display("FAIL timeout_latency: %0d cycles, required %0d", cyc, TO + 3); end
    checks++;
    if (err !== 1'b1 || core_busy !== 1'b1 || starts - s0 != 1) begin
      errors++;
      $display("FAIL timeout_flags: err=%0b core_busy=%0b starts=%0d, required 1/1/1", err, core_busy, starts - s0);
    end
    @(negedge clk);
    core_recover = 1'b1;
    @(negedge clk);
    core_recover = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int s0, cyc, seen;
    tbl[1] = 3; tbl[2] = 1; tbl[3] = 20;
    go_sweep(8'd1, 8'd3);
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_n, core_start, active, done, err, best_n, best_count} !== '0 || core_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: n=%0d act=%0b done=%0b err=%0b bn=%0d bc=%0d busy=%0b, required 0s and busy 1",
               core_n, active, done, err, best_n, best_count, core_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    go_sweep(8'd1, 8'd1);
    seen = 0;
    cyc = 0;
    while (core_busy && cyc < 40) begin
      if (core_start) seen++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (seen != 0 || cyc < 5) begin
      errors++;
      $display("FAIL midrun_hold: start seen %0d times while busy for %0d cycles, required 0 and >=5", seen, cyc);
    end
    wait_done(60, cyc);
    checks++;
    if (starts - s0 != 1 || best_n !== 8'd1 || best_count !== 8'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_result: starts=%0d best_n=%0d best_count=%0d err=%0b, required 1/1/3/0",
               starts - s0, best_n, best_count, err);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 1;
    test_reset();
    test_sweep_basic();
    test_single();
    test_zero_first();
    test_top_tie();
    test_bad_range();
    test_timeout();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
